// File: rtl/code_conv_pkg.sv
// Shared encodings and sizing helper for the sequenced code converter.
package code_conv_pkg;

  localparam logic [1:0] MODE_B2G     = 2'd0;
  localparam logic [1:0] MODE_G2B     = 2'd1;
  localparam logic [1:0] MODE_B2BCD   = 2'd2;
  localparam logic [1:0] MODE_BCD2XS3 = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // BCD digits needed for a w-bit binary value: ceil(w * log10(2)).
  function automatic int unsigned calc_ndig(input int unsigned w);
    return (w * 302 + 999) / 1000;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift in one binary bit.
module bcd_dabble_step #(
  parameter int unsigned NDIG = 2
) (
  input  logic [4*NDIG-1:0] bcd_i,
  input  logic              bit_i,
  output logic [4*NDIG-1:0] bcd_o
);

  logic [4*NDIG-1:0] adj;

  always_comb begin
    adj = bcd_i;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_i[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_o = {adj[4*NDIG-2:0], bit_i};

endmodule

// File: rtl/code_conv_seq.sv
// Sequenced W-bit converter (B2G, G2B, B2BCD, BCD2XS3) with start/busy/done handshake.
// Define CONV_PARITY_EN to add the registered dout_par output.
module code_conv_seq
  import code_conv_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [1:0]                mode,
  input  logic [W-1:0]              din,
  output logic                      busy,
  output logic                      done,
  output logic [4*calc_ndig(W)-1:0] dout,
  output logic                      err
`ifdef CONV_PARITY_EN
  ,
  output logic                      dout_par
`endif
);

  localparam int unsigned NDIG = calc_ndig(W);
  localparam int unsigned OW   = 4 * NDIG;
  localparam int unsigned NNIB = (W + 3) / 4;
  localparam int unsigned PW   = 4 * NNIB;
  localparam int unsigned CW   = $clog2(W + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      mode_q, mode_d;
  logic [W-1:0]    din_q, din_d;
  logic [OW-1:0]   acc_q, acc_d;
  logic [OW-1:0]   dout_q, dout_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic [OW-1:0]   dabble_out, result;
  logic [PW-1:0]   dpad;
  logic [3:0]      nib;
  logic            xs3_err;
  logic            g2b_bit;
  logic            finish;

  bcd_dabble_step #(
    .NDIG(NDIG)
  ) u_dabble (
    .bcd_i(acc_q),
    .bit_i(din_q[W-1]),
    .bcd_o(dabble_out)
  );

  assign dpad    = PW'(din_q);
  assign g2b_bit = acc_q[0] ^ din_q[W-1];

  // Step/result datapath; for serial modes the result is also the next accumulator.
  always_comb begin
    result  = '0;
    xs3_err = 1'b0;
    nib     = '0;
    case (mode_q)
      MODE_B2G:   result[W-1:0] = din_q ^ (din_q >> 1);
      MODE_G2B:   result = {acc_q[OW-2:0], g2b_bit};
      MODE_B2BCD: result = dabble_out;
      default: begin
        for (int i = 0; i < NNIB; i++) begin
          nib = dpad[4*i +: 4];
          result[4*i +: 4] = nib + 4'd3;
          if (nib > 4'd9) xs3_err = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    din_d   = din_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    err_d   = err_q;
    done_d  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          mode_d  = mode;
          din_d   = din;
          acc_d   = '0;
          cnt_d   = (mode == MODE_G2B || mode == MODE_B2BCD) ? CW'(W) : CW'(1);
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          acc_d = result;
          din_d = din_q << 1;
          if (cnt_q == CW'(1)) begin
            finish  = 1'b1;
            state_d = ST_IDLE;
            dout_d  = result;
            err_d   = xs3_err;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      din_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      din_q   <= din_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

`ifdef CONV_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (finish) par_d = ^result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign dout_par = par_q;
`endif

  always_comb begin
    busy = (state_q == ST_RUN);
    done = done_q;
    dout = dout_q;
    err  = err_q;
  end

endmodule
